inst_queue: RTL

- Parametrised, handshaked successor to the fixed IF/ID pipeline register.
- Buffers up to DEPTH fetched instructions. Each entry holds {pc, inst, fault}.
- Sits between the fetch unit and decode. Decouples fetch from decode stalls with valid/ready on both sides.
- Supports a single-cycle flush on branch or trap redirect.

---
 rtl/inst_queue_pkg.sv | 17 +
 rtl/inst_queue_ram.sv | 31 +++
 rtl/inst_queue.sv | 106 ++++++++++
 3 files changed

// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: shared constants for the instruction queue slice.
//   XLEN_BUS     - default pc width
//   INST_LEN_BUS - default instruction width
//   INST_NOP     - canonical NOP (addi x0, x0, 0) shown to decode when idle
//   entry_width  - packed width of one {pc, inst, fault} queue entry
package inst_queue_pkg;

    localparam int unsigned XLEN_BUS     = 64;
    localparam int unsigned INST_LEN_BUS = 32;
    localparam logic [31:0] INST_NOP     = 32'h0000_0013;

    function automatic int unsigned entry_width(input int unsigned xlen,
                                                input int unsigned inst_len);
        return xlen + inst_len + 1;
    endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// inst_queue_ram: DEPTH x WIDTH register array backing the instruction queue.
//   clk   - rising-edge write clock
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - asynchronous read address
//   rdata - read data (combinational from raddr)
// Storage is intentionally not reset; the owner masks unused contents.
module inst_queue_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 97
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/inst_queue.sv
// inst_queue: handshaked FIFO between fetch and decode, replacing the fixed
// IF/ID register. Holds up to DEPTH {pc, inst, fault} entries.
//   clk         - rising-edge clock
//   rst         - asynchronous active-low reset
//   flush_i     - redirect; empties the queue at the next edge
//   in_valid_i  / in_ready_o  - fetch-side handshake
//   in_pc_i, in_inst_i, in_fault_i - fetch payload
//   out_valid_o / out_ready_i - decode-side handshake
//   out_pc_o, out_inst_o, out_fault_o - head payload (NOP-masked when invalid)
//   count_o     - occupancy, 0..DEPTH
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int unsigned XLEN     = XLEN_BUS,
    parameter int unsigned INST_LEN = INST_LEN_BUS,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [XLEN-1:0]     in_pc_i,
    input  logic [INST_LEN-1:0] in_inst_i,
    input  logic                in_fault_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [XLEN-1:0]     out_pc_o,
    output logic [INST_LEN-1:0] out_inst_o,
    output logic                out_fault_o,
    output logic [CNT_W-1:0]    count_o
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned ENTRY_W = entry_width(XLEN, INST_LEN);
    localparam logic [INST_LEN-1:0] NOP_WORD = INST_LEN'(INST_NOP);

    logic [PTR_W-1:0]   head_q;
    logic [PTR_W-1:0]   tail_q;
    logic [CNT_W-1:0]   count_q;
    logic               enq;
    logic               deq;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;

    // in_ready depends only on registered occupancy, never on out_ready_i.
    assign in_ready_o  = (count_q != CNT_W'(DEPTH));
    assign out_valid_o = (count_q != '0) && !flush_i;

    assign enq = in_valid_i && in_ready_o && !flush_i;
    assign deq = out_valid_o && out_ready_i;

    assign wr_entry = {in_pc_i, in_inst_i, in_fault_i};

    inst_queue_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk   (clk),
        .we    (enq),
        .waddr (tail_q),
        .wdata (wr_entry),
        .raddr (head_q),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (enq) begin
                tail_q <= tail_q + PTR_W'(1);
            end
            if (deq) begin
                head_q <= head_q + PTR_W'(1);
            end
            case ({enq, deq})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Unreset storage may hold stale or X data; never let it reach decode.
    always_comb begin
        out_pc_o    = '0;
        out_inst_o  = NOP_WORD;
        out_fault_o = 1'b0;
        if (out_valid_o) begin
            out_pc_o    = rd_entry[ENTRY_W-1 -: XLEN];
            out_inst_o  = rd_entry[INST_LEN:1];
            out_fault_o = rd_entry[0];
        end
    end

    assign count_o = count_q;

endmodule
